// File: rtl/pipeline_stage_skid.sv
// Pipeline stage register carrying a control bundle and NUM_DATA data words,
// with a valid/ready handshake, an optional two-entry skid buffer and a synchronous flush.
module pipeline_stage_skid #(
  parameter int unsigned CTRL_W   = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_DATA = 4,
  parameter int unsigned SKID     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0]   in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0]   out_data,
  output logic [1:0]                   occ
);

  localparam int unsigned DW       = NUM_DATA * DATA_W;
  localparam bit          HAS_SKID = (SKID != 0);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DW-1:0]     main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DW-1:0]     skid_data_q,  skid_data_d;
  logic              in_ready_q,   in_ready_d;
  logic              accept, emit;

  // Registered ready when skidding; otherwise ready is open whenever main drains this cycle.
  assign in_ready = HAS_SKID ? in_ready_q : (!main_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign emit     = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (emit) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || emit) begin
      main_valid_d = accept;
      if (accept) begin
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end
    end else if (accept && HAS_SKID) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl;
      skid_data_d  = in_data;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Invalid entries present a zero (bubble) control bundle.
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign occ       = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule
